// File: rtl/axis_channel_sync.sv
// axis_channel_sync
// Handshake and frame-alignment controller in front of the four-channel
// real/imag beamforming adder. Every enabled input stream advances on the same
// cycle. Frame boundaries are checked against a programmed length, and on a
// misalignment the streams are flushed to a common frame boundary. No data
// passes through this block; tdata routes straight to the adder.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   enable                  run request
//   stream_mask             participating streams, latched on IDLE->RUN
//   frame_len               beats per frame (0 = unchecked), latched on IDLE->RUN
//   clear_status            clears sticky flags and error_count
//   s_tvalid/s_tlast/s_tready  per-stream AXI-Stream sideband
//   m_tvalid/m_tready/m_tlast  joined handshake toward the adder
//   state                   0=IDLE, 1=RUN, 2=FLUSH
//   frame_count             good frames completed (wraps)
//   error_count             misalignment events (saturates)
//   misalign_flag           sticky misalignment indicator
//   timeout_flag            sticky partial-valid timeout indicator
module axis_channel_sync #(
    parameter int NUM_STREAMS    = 8,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_STREAMS-1:0] stream_mask,
    input  logic [CNT_WIDTH-1:0]   frame_len,
    input  logic                   clear_status,
    input  logic [NUM_STREAMS-1:0] s_tvalid,
    input  logic [NUM_STREAMS-1:0] s_tlast,
    output logic [NUM_STREAMS-1:0] s_tready,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic [1:0]             state,
    output logic [CNT_WIDTH-1:0]   frame_count,
    output logic [CNT_WIDTH-1:0]   error_count,
    output logic                   misalign_flag,
    output logic                   timeout_flag
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_STREAMS-1:0] mask_q, mask_d;
    logic [NUM_STREAMS-1:0] done_q, done_d;
    logic [CNT_WIDTH-1:0]   len_q, len_d;
    logic [CNT_WIDTH-1:0]   beat_q, beat_d;
    logic [CNT_WIDTH-1:0]   frames_q, frames_d;
    logic [CNT_WIDTH-1:0]   errors_q, errors_d;
    logic                   misalign_q, misalign_d;
    logic                   timeout_q, timeout_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;

    logic                 in_run, in_flush;
    logic                 all_v, any_v, any_l, all_l, fire;
    logic [CNT_WIDTH-1:0] len_m1, err_base;
    logic                 at_end, before_end;
    logic                 good_last, good_mid, err_early, err_partial, err_missing, err_evt;
    logic                 flush_done, partial_v, to_hit;

    assign in_run   = (state_q == ST_RUN);
    assign in_flush = (state_q == ST_FLUSH);

    // Masked-off streams count as valid/last so they never block the join.
    assign all_v = &(s_tvalid | ~mask_q);
    assign any_v = |(s_tvalid & mask_q);
    assign any_l = |(s_tlast & mask_q);
    assign all_l = &(s_tlast | ~mask_q);
    assign fire  = in_run & all_v & m_tready;

    assign len_m1     = len_q - CNT_WIDTH'(1);
    assign at_end     = (len_q != '0) && (beat_q == len_m1);
    assign before_end = (len_q != '0) && (beat_q < len_m1);

    // Beat classification; exactly one of these is set on every fire.
    assign err_partial = fire & any_l & ~all_l;
    assign good_last   = fire & all_l & ~before_end;
    assign err_early   = fire & all_l & before_end;
    assign err_missing = fire & ~any_l & at_end;
    assign good_mid    = fire & ~any_l & ~at_end;
    assign err_evt     = err_partial | err_early | err_missing;

    // Uses the registered done set, so a flush always spans at least one cycle.
    assign flush_done = &(done_q | ~mask_q);

    assign partial_v = in_run & any_v & ~all_v;
    assign to_hit    = partial_v & (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    assign m_tvalid = in_run & all_v;
    assign m_tlast  = m_tvalid & (at_end | any_l);

    always_comb begin
        s_tready = '0;
        if (in_run && all_v && m_tready) begin
            s_tready = mask_q;
        end else if (in_flush) begin
            s_tready = mask_q & ~done_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        len_d    = len_q;
        beat_d   = beat_q;
        done_d   = done_q;
        frames_d = frames_q;

        case (state_q)
            ST_IDLE: begin
                if (enable && (stream_mask != '0)) begin
                    state_d = ST_RUN;
                    mask_d  = stream_mask;
                    len_d   = frame_len;
                    beat_d  = '0;
                    done_d  = '0;
                end
            end
            ST_RUN: begin
                if (good_last || err_early) begin
                    beat_d = '0;
                    if (good_last) frames_d = frames_q + CNT_WIDTH'(1);
                    if (!enable) state_d = ST_IDLE;
                end else if (good_mid) begin
                    beat_d = beat_q + CNT_WIDTH'(1);
                end else if (err_partial) begin
                    // Streams that already delivered their tlast are finished.
                    done_d  = s_tlast & mask_q;
                    state_d = ST_FLUSH;
                end else if (err_missing) begin
                    done_d  = '0;
                    state_d = ST_FLUSH;
                end else if (!enable && (beat_q == '0)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (flush_done) begin
                    beat_d  = '0;
                    done_d  = '0;
                    state_d = enable ? ST_RUN : ST_IDLE;
                end else begin
                    done_d = done_q | (s_tvalid & s_tready & s_tlast);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status: a set event in the same cycle as clear_status wins.
    always_comb begin
        err_base   = clear_status ? '0 : errors_q;
        errors_d   = err_base;
        if (err_evt && (err_base != '1)) errors_d = err_base + CNT_WIDTH'(1);
        misalign_d = err_evt | (misalign_q & ~clear_status);
        timeout_d  = to_hit | (timeout_q & ~clear_status);
        to_cnt_d   = '0;
        if (partial_v) begin
            to_cnt_d = (to_cnt_q == TO_W'(TIMEOUT_CYCLES)) ? to_cnt_q : to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            done_q     <= '0;
            frames_q   <= '0;
            errors_q   <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            done_q     <= done_d;
            frames_q   <= frames_d;
            errors_q   <= errors_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign state         = state_q;
    assign frame_count   = frames_q;
    assign error_count   = errors_q;
    assign misalign_flag = misalign_q;
    assign timeout_flag  = timeout_q;

endmodule

// File: doc/axis_channel_sync.md
Name: axis_channel_sync

Overview:
- Handshake and frame-alignment controller in front of the four-channel real/imag beamforming adder.
- Joins NUM_STREAMS AXI-Stream valid/ready/last sideband sets (ch00/01/20/21 × real/imag) into one lockstep transfer, so every enabled stream advances on the same cycle.
- Checks frame boundaries against a programmed length. On misalignment it flushes the streams to a common frame boundary.
- Carries no data; tdata routes straight to the adder.

Parameters:
- NUM_STREAMS, 8, number of joined input streams.
- CNT_WIDTH, 16, width of beat, frame and error counters and of frame_len.
- TIMEOUT_CYCLES, 1024, consecutive partial-valid cycles before timeout_flag sets.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request.
- stream_mask  in  NUM_STREAMS  1 = stream participates; sampled on IDLE->RUN.
- frame_len  in  CNT_WIDTH  beats per frame; 0 = no length check; sampled on IDLE->RUN.
- clear_status  in  1  clears sticky flags and error_count.
- s_tvalid  in  NUM_STREAMS  per-stream tvalid.
- s_tlast  in  NUM_STREAMS  per-stream tlast.
- s_tready  out  NUM_STREAMS  per-stream tready.
- m_tvalid  out  1  joined valid to adder.
- m_tready  in  1  adder/downstream ready.
- m_tlast  out  1  joined frame end.
- state  out  2  0=IDLE, 1=RUN, 2=FLUSH.
- frame_count  out  CNT_WIDTH  good frames completed; wraps.
- error_count  out  CNT_WIDTH  misalignment events; saturates at all-ones.
- misalign_flag  out  1  sticky; set on any misalignment.
- timeout_flag  out  1  sticky; set on partial-valid timeout.

Behaviour:
- Reset values: state=IDLE; s_tready=0; m_tvalid=0; m_tlast=0; frame_count=0; error_count=0; both flags=0; beat_cnt=0; mask_r=0; len_r=0; done=0.
- Definitions:
  - all_v = &(s_tvalid | ~mask_r).
  - fire = (state==RUN) & all_v & m_tready.
  - any_l = |(s_tlast & mask_r).
  - all_l = &(s_tlast | ~mask_r).
- Outputs are combinational from registered state and the inputs, giving zero-latency pass-through:
  - m_tvalid = (state==RUN) & all_v.
  - RUN: s_tready[i] = mask_r[i] & all_v & m_tready.
  - FLUSH: s_tready[i] = mask_r[i] & ~done[i].
  - IDLE: s_tready = 0.
  - Masked-off streams always see s_tready=0.
- m_tlast, while m_tvalid is high:
  - len_r!=0: m_tlast = (beat_cnt==len_r-1) | any_l.
  - len_r==0: m_tlast = any_l.
- IDLE -> RUN when enable=1 and stream_mask!=0. Latches mask_r and len_r and clears beat_cnt. If stream_mask==0, stay in IDLE.
- RUN, on fire, classify the beat:
  - Good last: all_l=1, and either len_r==0 or beat_cnt==len_r-1. Then frame_count+1 and beat_cnt=0.
  - Good mid: any_l=0, and either len_r==0 or beat_cnt<len_r-1. Then beat_cnt+1.
  - Early uniform: all_l=1 with beat_cnt<len_r-1. Counts as an error; beat_cnt=0; stay in RUN (no flush needed).
  - Partial: any_l=1 and all_l=0. Counts as an error; done = s_tlast & mask_r; go to FLUSH.
  - Missing: any_l=0 and beat_cnt==len_r-1. Counts as an error; done=0; go to FLUSH.
  - Any error: error_count+1 (saturating) and misalign_flag=1.
- FLUSH:
  - m_tvalid=0.
  - done[i] sets on s_tvalid[i] & s_tready[i] & s_tlast[i].
  - Non-last beats on undone streams are accepted and discarded.
  - When (done | ~mask_r) is all ones: beat_cnt=0, done=0, return to RUN. Evaluated with the registered done, so FLUSH lasts at least 1 cycle.
  - enable=0 during FLUSH: finish the flush, then go to IDLE.
- enable=0 in RUN:
  - At beat_cnt==0 with no fire this cycle: go to IDLE next cycle.
  - Otherwise: continue until a good-last or error beat. Good last or early uniform -> IDLE. Partial or missing -> FLUSH, then IDLE.
- Timeout counter:
  - Counts cycles in RUN with some, but not all, enabled s_tvalid high.
  - Clears on fire, on all-enabled-invalid, or outside RUN.
  - Reaching TIMEOUT_CYCLES sets timeout_flag. No state change.
- clear_status clears misalign_flag, timeout_flag and error_count. If clear_status coincides with a set event, the set wins.
- Reset mid-frame returns to IDLE immediately. No flush occurs; software re-enables at a known boundary.

Test Plan:
- Aligned run: mask=0xFF, frame_len=4, all valid, m_tready=1, tlast on beat 3 of 3 frames -> 12 fires, m_tlast on cycles 3/7/11, frame_count=3, error_count=0.
- Backpressure and stall: frame_len=4; stream 5 drops tvalid for 3 cycles mid-frame; m_tready low 2 cycles -> s_tready all 0 during stalls, no beat lost, frame_count=1, timeout_flag=0.
- Partial tlast: streams 0-3 tlast at beat 2, streams 4-7 at beat 3, frame_len=0 -> error_count=1, state=FLUSH. Streams 0-3 are not readied again. Streams 4-7 have one beat drained. Return to RUN; next aligned frame gives frame_count+1.
- Missing tlast: frame_len=4, no tlast at beat 3, tlast at beat 5 on all -> beat 3 fires with m_tlast=1, misalign_flag=1. FLUSH consumes beats 4-5, then RUN.
- Timeout and masking: mask=0x0F, stream 2 valid low for 1024 cycles while 0,1,3 valid -> timeout_flag=1 at cycle 1024. Streams 4-7 s_tready stay 0 throughout. clear_status -> flag 0.
- Enable drop and reset: enable=0 at beat 1 of a 4-beat frame -> beats 2-3 complete, then IDLE. Reset asserted mid-frame -> IDLE next cycle, all outputs at reset values.
